// File: rtl/frame_cfg_pkg.sv
// Shared constants and types for the bitstream frame writer:
// header opcode, header field positions and the writer state encoding.
package frame_cfg_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [7:0]  FRAME_OPCODE = 8'hFA;

  // Header field positions (each field is one byte wide)
  localparam int          HDR_FIELD_W  = 8;
  localparam int          HDR_OP_LSB   = 24;
  localparam int          HDR_COL_LSB  = 16;
  localparam int          HDR_FRM_LSB  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DISCARD = 3'd5
  } wr_state_e;

  // Extract one byte-wide header field starting at bit lsb
  function automatic logic [HDR_FIELD_W-1:0] hdr_field(input logic [WORD_W-1:0] word,
                                                       input int lsb);
    return word[lsb +: HDR_FIELD_W];
  endfunction

endpackage

// File: rtl/bitstream_frame_writer_if.sv
// Bitstream word handshake between the loader (master) and the frame writer (slave).
interface bitstream_frame_writer_if;
  import frame_cfg_pkg::*;

  logic [WORD_W-1:0] WriteData;
  logic              WriteStrobe;
  logic              Ready;

  modport master (output WriteData, output WriteStrobe, input Ready);
  modport slave  (input WriteData, input WriteStrobe, output Ready);

endinterface

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of (column, frame, enable) onto the flat
// column/frame strobe vector. Out-of-range coordinates never raise a bit.
module frame_strobe_decoder #(
  parameter int NumCols         = 10,
  parameter int MaxFramesPerCol = 20,
  parameter int ColW            = $clog2(NumCols),
  parameter int FrmW            = $clog2(MaxFramesPerCol)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [ColW-1:0]                     i_col,
  input  logic [FrmW-1:0]                     i_frame,
  input  logic                                i_en,
  output logic [NumCols*MaxFramesPerCol-1:0]  o_strobe
);

  localparam int NumBits = NumCols * MaxFramesPerCol;
  localparam int IdxW    = $clog2(NumBits);

  logic [IdxW-1:0]    w_idx;
  logic               w_idx_ok;
  logic [NumBits-1:0] w_onehot;
  logic [NumBits-1:0] r_strobe;

  // Flat bit index and one-hot pattern for the requested column/frame
  always_comb begin
    w_idx    = IdxW'(i_col) * IdxW'(MaxFramesPerCol) + IdxW'(i_frame);
    w_idx_ok = (int'(i_col) < NumCols) && (int'(i_frame) < MaxFramesPerCol);
    w_onehot = '0;
    if (i_en && w_idx_ok) begin
      w_onehot[w_idx] = 1'b1;
    end else begin
      w_onehot = '0;
    end
  end

  // Strobe register: one cycle high per enable, cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_strobe <= '0;
    end else begin
      r_strobe <= w_onehot;
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/bitstream_frame_writer.sv
// Frame writer: parses a header word, loads NumRows row words into the
// row registers, then fires a single column/frame strobe and a FrameDone pulse.
// Bad headers set a sticky ConfigError; out-of-range headers swallow their rows.
module bitstream_frame_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 14,
  parameter int NumCols         = 10
) (
  input  logic                                UserCLK,
  input  logic                                reset,
  bitstream_frame_writer_if.slave             wr_if,
  output logic [NumRows*FrameBitsPerRow-1:0]  RowFrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]  ColFrameStrobe,
  output logic                                FrameDone,
  output logic                                ConfigError
);
  import frame_cfg_pkg::*;

  localparam int              RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int              ColW    = $clog2(NumCols);
  localparam int              FrmW    = $clog2(MaxFramesPerCol);
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  wr_state_e            r_state, w_state_nxt;
  logic [RowW-1:0]      r_row_cnt, w_row_cnt_nxt;
  logic [ColW-1:0]      r_col, w_col_nxt;
  logic [FrmW-1:0]      r_frame, w_frame_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_frame_done, w_frame_done_nxt;
  logic                 r_config_error, w_config_error_nxt;
  logic                 w_accept, w_row_we, w_strobe_en;
  logic [HDR_FIELD_W-1:0] w_hdr_op, w_hdr_col, w_hdr_frame;
  logic [FrameBitsPerRow-1:0] r_rows [NumRows];

  assign w_accept    = wr_if.WriteStrobe && r_ready;
  assign w_hdr_op    = hdr_field(wr_if.WriteData, HDR_OP_LSB);
  assign w_hdr_col   = hdr_field(wr_if.WriteData, HDR_COL_LSB);
  assign w_hdr_frame = hdr_field(wr_if.WriteData, HDR_FRM_LSB);

  // Next-state, counter, header latch and registered-output next values
  always_comb begin
    w_state_nxt        = r_state;
    w_row_cnt_nxt      = r_row_cnt;
    w_col_nxt          = r_col;
    w_frame_nxt        = r_frame;
    w_config_error_nxt = r_config_error;
    w_row_we           = 1'b0;
    w_strobe_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hdr_op != FRAME_OPCODE) begin
            w_config_error_nxt = 1'b1;
          end else if ((int'(w_hdr_col) < NumCols) && (int'(w_hdr_frame) < MaxFramesPerCol)) begin
            w_col_nxt     = ColW'(w_hdr_col);
            w_frame_nxt   = FrmW'(w_hdr_frame);
            w_row_cnt_nxt = '0;
            w_state_nxt   = ST_LOAD;
          end else begin
            w_config_error_nxt = 1'b1;
            w_row_cnt_nxt      = '0;
            w_state_nxt        = ST_DISCARD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_row_we = 1'b1;
          if (r_row_cnt == LastRow) begin
            w_row_cnt_nxt = '0;
            w_state_nxt   = ST_SETUP;
          end else begin
            w_row_cnt_nxt = r_row_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_SETUP: begin
        // Rows are stable; arm the strobe register for the next cycle
        w_strobe_en = 1'b1;
        w_state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      ST_DISCARD: begin
        if (w_accept) begin
          if (r_row_cnt == LastRow) begin
            w_row_cnt_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_row_cnt_nxt = r_row_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_row_cnt_nxt = '0;
      end
    endcase
    w_ready_nxt      = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                       (w_state_nxt == ST_DISCARD);
    w_frame_done_nxt = (r_state == ST_STROBE);
  end

  // State register plus row counter and latched column/frame
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_row_cnt <= '0;
      r_col     <= '0;
      r_frame   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_col     <= w_col_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  // Registered handshake and status outputs
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_ready        <= 1'b0;
      r_frame_done   <= 1'b0;
      r_config_error <= 1'b0;
    end else begin
      r_ready        <= w_ready_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_config_error <= w_config_error_nxt;
    end
  end

  // Row registers: only the addressed row is replaced, and only in LOAD
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      for (int r = 0; r < NumRows; r++) begin
        r_rows[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NumRows; r++) begin
        if (w_row_we && (r_row_cnt == RowW'(r))) begin
          r_rows[r] <= wr_if.WriteData[FrameBitsPerRow-1:0];
        end else begin
          r_rows[r] <= r_rows[r];
        end
      end
    end
  end

  frame_strobe_decoder #(
    .NumCols         (NumCols),
    .MaxFramesPerCol (MaxFramesPerCol),
    .ColW            (ColW),
    .FrmW            (FrmW)
  ) u_strobe_dec (
    .i_clk    (UserCLK),
    .i_rst    (reset),
    .i_col    (r_col),
    .i_frame  (r_frame),
    .i_en     (w_strobe_en),
    .o_strobe (ColFrameStrobe)
  );

  for (genvar g = 0; g < NumRows; g++) begin : g_row_out
    assign RowFrameData[g*FrameBitsPerRow +: FrameBitsPerRow] = r_rows[g];
  end

  assign wr_if.Ready = r_ready;
  assign FrameDone   = r_frame_done;
  assign ConfigError = r_config_error;

endmodule

// File: tb/tb_bitstream_frame_writer.sv
// Directed bench for bitstream_frame_writer: table of header/packet vectors
// plus hand sequences for stalls, mid-packet reset and back-to-back packets.
module tb_bitstream_frame_writer;

  localparam int NR = 14;
  localparam int NC = 10;
  localparam int NF = 20;
  localparam int FB = 32;
  localparam int RW = NR * FB;
  localparam int SW = NC * NF;

  logic          UserCLK = 1'b0;
  logic          reset;
  logic [RW-1:0] RowFrameData;
  logic [SW-1:0] ColFrameStrobe;
  logic          FrameDone;
  logic          ConfigError;

  bitstream_frame_writer_if wr_if ();

  bitstream_frame_writer #(
    .MaxFramesPerCol (NF),
    .FrameBitsPerRow (FB),
    .NumRows         (NR),
    .NumCols         (NC)
  ) dut (
    .UserCLK        (UserCLK),
    .reset          (reset),
    .wr_if          (wr_if),
    .RowFrameData   (RowFrameData),
    .ColFrameStrobe (ColFrameStrobe),
    .FrameDone      (FrameDone),
    .ConfigError    (ConfigError)
  );

  always #5 UserCLK = ~UserCLK;

  // kind: 0 = valid packet, 1 = bad opcode (header only), 2 = out-of-range header + discarded rows
  typedef struct {
    logic [31:0] hdr;
    logic [31:0] base;
    int          kind;
    int          bitpos;
    logic        exp_err;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_strobe_cyc = 0;
  logic [FB-1:0] model [NR];
  vec_t        tbl [8];

  // Strobe monitor: count pulses, remember when they occur, demand one-hot
  always @(negedge UserCLK) begin
    cyc++;
    if (ColFrameStrobe != '0) begin
      pulses++;
      last_strobe_cyc = cyc;
      checks++;
      if ($countones(ColFrameStrobe) != 1) begin
        errors++;
        $display("FAIL strobe_onehot: got %0d bits set, expected 1", $countones(ColFrameStrobe));
      end
    end
  end

  function automatic logic [RW-1:0] model_vec();
    logic [RW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*FB +: FB] = model[r];
    return v;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one word at a negedge once Ready is seen; optional idle gap afterwards
  task automatic put(input logic [31:0] w, input int gap);
    int n;
    n = 0;
    while (wr_if.Ready !== 1'b1 && n < 40) begin
      @(negedge UserCLK);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: Ready stayed %b, expected 1", wr_if.Ready);
    end
    wr_if.WriteData   = w;
    wr_if.WriteStrobe = 1'b1;
    @(negedge UserCLK);
    wr_if.WriteStrobe = 1'b0;
    wr_if.WriteData   = 32'hDEAD_BEEF;
    repeat (gap) @(negedge UserCLK);
  endtask

  task automatic send_packet(input vec_t v, input bit stall);
    int            p0;
    logic [SW-1:0] exp_s;
    #1;
    p0 = pulses;
    put(v.hdr, 0);
    case (v.kind)
      0: begin
        for (int r = 0; r < NR; r++) begin
          put(v.base + 32'(r), (stall && r >= 3 && r <= 6) ? 1 : 0);
          model[r] = v.base + 32'(r);
          chk("row_load", RowFrameData[r*FB +: FB], model[r]);
        end
        chk("setup_rows", RowFrameData, model_vec());
        chk("setup_ready", wr_if.Ready, 0);
        chk("setup_strobe", ColFrameStrobe, 0);
        @(negedge UserCLK);
        exp_s = '0;
        exp_s[v.bitpos] = 1'b1;
        chk("strobe_bit", ColFrameStrobe, exp_s);
        chk("strobe_done_low", FrameDone, 0);
        @(negedge UserCLK);
        chk("hold_strobe", ColFrameStrobe, 0);
        chk("hold_done", FrameDone, 1);
        chk("hold_ready", wr_if.Ready, 0);
        chk("hold_rows", RowFrameData, model_vec());
        @(negedge UserCLK);
        chk("idle_ready", wr_if.Ready, 1);
        chk("idle_done", FrameDone, 0);
        chk("idle_err", ConfigError, v.exp_err);
        #1;
        chk("pulse_count", pulses, p0 + 1);
      end
      1: begin
        chk("badop_ready", wr_if.Ready, 1);
        chk("badop_err", ConfigError, 1);
        chk("badop_rows", RowFrameData, model_vec());
        #1;
        chk("badop_pulses", pulses, p0);
      end
      default: begin
        chk("range_err", ConfigError, 1);
        chk("range_ready", wr_if.Ready, 1);
        for (int r = 0; r < NR; r++) put(v.base + 32'(r), 0);
        chk("discard_rows", RowFrameData, model_vec());
        chk("discard_ready", wr_if.Ready, 1);
        chk("discard_err", ConfigError, 1);
        #1;
        chk("discard_pulses", pulses, p0);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   s1, s2, p0;

    tbl[0] = '{32'hFA03_0500, 32'h1000_0000, 0, 65,  1'b0};
    tbl[1] = '{32'hFA04_0AFF, 32'h2000_0000, 0, 90,  1'b0};
    tbl[2] = '{32'h1200_0000, 32'h0000_0000, 1, 0,   1'b1};
    tbl[3] = '{32'hFA01_0200, 32'h3000_0000, 0, 22,  1'b1};
    tbl[4] = '{32'hFA0A_0000, 32'h4000_0000, 2, 0,   1'b1};
    tbl[5] = '{32'hFA00_1400, 32'h4100_0000, 2, 0,   1'b1};
    tbl[6] = '{32'hFAFF_FF00, 32'h4200_0000, 2, 0,   1'b1};
    tbl[7] = '{32'hFA09_1300, 32'h5000_0000, 0, 199, 1'b1};

    for (int r = 0; r < NR; r++) model[r] = '0;
    wr_if.WriteData   = 32'h0;
    wr_if.WriteStrobe = 1'b0;
    reset = 1'b1;

    // Reset values
    @(negedge UserCLK);
    chk("rst_ready", wr_if.Ready, 0);
    chk("rst_rows", RowFrameData, 0);
    chk("rst_strobe", ColFrameStrobe, 0);
    chk("rst_done", FrameDone, 0);
    chk("rst_err", ConfigError, 0);
    reset = 1'b0;
    @(negedge UserCLK);
    chk("post_rst_ready", wr_if.Ready, 1);

    // Stalled load: WriteStrobe 1-0-1 on rows 3..6 with junk data while low
    v = '{32'hFA02_0700, 32'h6000_0000, 0, 47, 1'b0};
    send_packet(v, 1'b1);

    // Back-to-back packets: bit 0 then bit 199, NumRows+4 cycles apart
    v = '{32'hFA00_0000, 32'h7000_0000, 0, 0, 1'b0};
    send_packet(v, 1'b0);
    s1 = last_strobe_cyc;
    v = '{32'hFA09_1300, 32'h7100_0000, 0, 199, 1'b0};
    send_packet(v, 1'b0);
    s2 = last_strobe_cyc;
    chk("b2b_spacing", s2 - s1, NR + 4);

    // Reset after 7 of 14 rows: everything back to zero, no strobe ever
    #1;
    p0 = pulses;
    put(32'hFA05_0500, 0);
    for (int r = 0; r < 7; r++) put(32'h8000_0000 + 32'(r), 0);
    reset = 1'b1;
    @(negedge UserCLK);
    for (int r = 0; r < NR; r++) model[r] = '0;
    chk("midrst_rows", RowFrameData, 0);
    chk("midrst_strobe", ColFrameStrobe, 0);
    chk("midrst_ready", wr_if.Ready, 0);
    chk("midrst_done", FrameDone, 0);
    chk("midrst_err", ConfigError, 0);
    reset = 1'b0;
    repeat (4) @(negedge UserCLK);
    #1;
    chk("midrst_pulses", pulses, p0);
    chk("midrst_done_after", FrameDone, 0);
    v = '{32'hFA06_0100, 32'h9000_0000, 0, 121, 1'b0};
    send_packet(v, 1'b0);

    // Table-driven header/packet vectors
    for (int i = 0; i < 8; i++) begin
      send_packet(tbl[i], 1'b0);
    end

    repeat (3) @(negedge UserCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_frame_writer.md
# bitstream_frame_writer

Configuration-side writer for the fabric frame interface: it accepts a stream of 32-bit bitstream words, assembles one frame's worth of per-row data and drives the per-row frame-data buses and per-column frame-strobe lines that every tile (including the stacked DSP tile) latches from. It sits between the bitstream source (SPI/UART/Wishbone loader) and the fabric's row and column configuration ports. It is the transmitting end of the frame-data/frame-strobe protocol.

## Interface
- MaxFramesPerCol, 20, frames per column; frame-strobe width per column
- FrameBitsPerRow, 32, frame-data width per row
- NumRows, 14, fabric tile rows (one frame-data bus each)
- NumCols, 10, fabric tile columns (one frame-strobe bus each)
- UserCLK  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- WriteData  in  32  bitstream word
- WriteStrobe  in  1  WriteData valid; word accepted when WriteStrobe && Ready
- Ready  out  1  writer can accept a word this cycle
- RowFrameData  out  NumRows*FrameBitsPerRow  row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow]
- ColFrameStrobe  out  NumCols*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f
- FrameDone  out  1  one-cycle pulse after a frame strobe completes
- ConfigError  out  1  sticky; set on bad header, cleared only by reset

## Operation
- Packet: one header word, then exactly NumRows data words (row 0 first).
- Header: [31:24] opcode 8'hFA; [23:16] column; [15:8] frame index; [7:0] ignored.
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DISCARD.
- IDLE: Ready=1. Accepted word with opcode != 8'hFA: dropped, ConfigError set, stay IDLE. Valid opcode with column < NumCols and frame < MaxFramesPerCol: latch column/frame, row counter=0, go LOAD. Valid opcode with out-of-range column or frame: ConfigError set, go DISCARD.
- LOAD: Ready=1. Each accepted word written into row register [row counter]; counter increments; after row NumRows-1 accepted go SETUP.
- SETUP: Ready=0, one cycle, all rows stable. Go STROBE.
- STROBE: Ready=0, exactly one ColFrameStrobe bit (latched column/frame) high for one cycle. Go HOLD.
- HOLD: Ready=0, RowFrameData unchanged, FrameDone=1. Go IDLE.
- DISCARD: Ready=1, consumes NumRows words without touching RowFrameData; no strobe; then IDLE.
- RowFrameData is written only in LOAD; row registers not being written hold their value (bits of a row are replaced whole, never partially).
- ColFrameStrobe is one-hot or zero in every cycle.
- WriteStrobe low in LOAD/DISCARD: stall, counter holds; no timeout.

## Timing
- Reset values: Ready=0 during reset cycle, 1 the cycle after; RowFrameData=0; ColFrameStrobe=0; FrameDone=0; ConfigError=0; state IDLE.
- Row word accepted at edge t: that row visible on RowFrameData from t+1.
- Last row accepted at edge t: SETUP cycle t+1, strobe high cycle t+2 only, HOLD/FrameDone cycle t+3, Ready=1 again at t+4.
- Minimum packet period back-to-back: NumRows+4 cycles.
- Reset asserted mid-packet (any state): next cycle all outputs at reset values, partial frame dropped, no strobe ever emitted for it.
- Ready, ColFrameStrobe, FrameDone are registered outputs (no combinational path from WriteStrobe/WriteData).

## Structure
- Package frame_cfg_pkg: opcode constant 8'hFA, header field bit positions, state encoding typedef.
- Sub-module frame_strobe_decoder: registered one-hot decode of (column, frame, enable) into NumCols*MaxFramesPerCol strobe bits.
- Row registers and counter/FSM live in the top module.

## Test plan
- Reset then header 32'hFA_03_05_00 + 14 rows 32'h1000_0000+r -> row r reads 32'h1000_0000+r; bit 3*20+5=65 strobes for exactly one cycle 2 cycles after last row; FrameDone next cycle; ConfigError=0.
- Header 32'h12_00_00_00 -> dropped, ConfigError=1, Ready stays 1, no strobe; following valid packet still programs correctly.
- Header 32'hFA_0A_00_00 (column 10) or 32'hFA_00_14_00 (frame 20) -> ConfigError=1, next 14 words consumed, RowFrameData unchanged, no strobe.
- Valid packet with WriteStrobe toggled 1-0-1 during LOAD -> same RowFrameData and single strobe as unstalled run, delayed by stall cycles.
- Reset asserted after 7 of 14 rows -> outputs zero next cycle, no strobe; a fresh packet afterwards completes normally.
- Two back-to-back packets (col 0 frame 0, col 9 frame 19) -> strobes at bits 0 and 199, separated by 18 cycles, never overlapping.
